pcis_stream_bridge: RTL and testbench

- Protocol-correct bridge between the registered 512b DMA PCIS AXI4 slave bus and the 512b AXI-Stream datapath: width converters, FIFOs and the CNN.
- Write path: accepts AW/W bursts, forwards W beats as stream beats, returns one B per burst.
- Read path: queues AR requests and serves each burst from the returned stream with correct rid/rlast.
- Replaces the ad-hoc tie-offs and free-running beat counter on the PCIS response channels.

---
 rtl/pcis_bridge_pkg.sv | 16 +
 rtl/pcis_stream_bridge_if.sv | 83 ++++++++
 rtl/pcis_req_fifo.sv | 46 ++++
 rtl/pcis_stream_bridge.sv | 143 ++++++++++++++
 tb/tb_pcis_stream_bridge.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcis_bridge_pkg.sv
// Shared types and constants for the PCIS AXI4 <-> AXI-Stream bridge.
package pcis_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned PCIS_ID_W  = 6;
  localparam int unsigned PCIS_LEN_W = 8;

  // One queued AW or AR request; the address is not kept.
  typedef struct packed {
    logic [PCIS_ID_W-1:0]  id;
    logic [PCIS_LEN_W-1:0] len;
  } aq_entry_t;

endpackage

// File: rtl/pcis_stream_bridge_if.sv
// PCIS AXI4 slave bus plus the two 512b stream ports seen by the bridge.
interface pcis_stream_bridge_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned ADDR_W = 64
);
  logic [ID_W-1:0]     s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [7:0]          s_awlen;
  logic [2:0]          s_awsize;
  logic                s_awvalid;
  logic                s_awready;

  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wlast;
  logic                s_wvalid;
  logic                s_wready;

  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  logic [ID_W-1:0]     s_arid;
  logic [ADDR_W-1:0]   s_araddr;
  logic [7:0]          s_arlen;
  logic [2:0]          s_arsize;
  logic                s_arvalid;
  logic                s_arready;

  logic [ID_W-1:0]     s_rid;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic                s_rvalid;
  logic                s_rready;

  logic [DATA_W-1:0]   m_axis_tdata;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;

  logic [DATA_W-1:0]   s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;

  // Bridge view: AXI slave, stream source on m_axis, stream sink on s_axis.
  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  // Environment view: DMA host plus the width converters.
  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );
endinterface

// File: rtl/pcis_req_fifo.sv
// Small synchronous request FIFO with a registered head entry view.
module pcis_req_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pcis_stream_bridge.sv
// PCIS AXI4 slave to AXI-Stream bridge: W beats become stream beats with one B per
// burst; AR requests are queued and served from the returned stream.
module pcis_stream_bridge
  import pcis_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned ID_W     = PCIS_ID_W,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned AQ_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pcis_stream_bridge_if.slave bus
);
  aq_entry_t aw_in, aw_head, ar_in, ar_head;
  logic      aw_full, aw_empty, aw_pop;
  logic      ar_full, ar_empty, ar_pop;

  logic [7:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic            werr_q, werr_d;
  logic            bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;

  logic w_ok, w_hs, w_last, w_beat_err;
  logic r_hs, r_last;

  // Address, size and strobes carry nothing the stream needs.
  logic [ADDR_W-1:0]   unused_awaddr, unused_araddr;
  logic [2:0]          unused_awsize, unused_arsize;
  logic [DATA_W/8-1:0] unused_wstrb;
  assign unused_awaddr = bus.s_awaddr;
  assign unused_araddr = bus.s_araddr;
  assign unused_awsize = bus.s_awsize;
  assign unused_arsize = bus.s_arsize;
  assign unused_wstrb  = bus.s_wstrb;

  assign aw_in = '{id: bus.s_awid, len: bus.s_awlen};
  assign ar_in = '{id: bus.s_arid, len: bus.s_arlen};

  pcis_req_fifo #(
    .WIDTH ($bits(aq_entry_t)),
    .DEPTH (AQ_DEPTH)
  ) u_aw_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.s_awvalid),
    .wdata (aw_in),
    .pop   (aw_pop),
    .head  (aw_head),
    .full  (aw_full),
    .empty (aw_empty)
  );

  pcis_req_fifo #(
    .WIDTH ($bits(aq_entry_t)),
    .DEPTH (AQ_DEPTH)
  ) u_ar_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.s_arvalid),
    .wdata (ar_in),
    .pop   (ar_pop),
    .head  (ar_head),
    .full  (ar_full),
    .empty (ar_empty)
  );

  assign bus.s_awready = ~aw_full;
  assign bus.s_arready = ~ar_full;

  // Write path: a burst may only flow once its AW is queued and the previous B is gone.
  assign w_ok              = ~aw_empty & ~bvalid_q;
  assign bus.s_wready      = bus.m_axis_tready & w_ok;
  assign bus.m_axis_tvalid = bus.s_wvalid & w_ok;
  assign bus.m_axis_tdata  = bus.s_wdata;
  assign w_hs              = bus.s_wvalid & bus.s_wready;
  assign w_last            = (wcnt_q == aw_head.len);
  assign w_beat_err        = (bus.s_wlast != w_last);
  assign bus.m_axis_tlast  = w_last;
  assign aw_pop            = w_hs & w_last;

  assign bus.s_bvalid = bvalid_q;
  assign bus.s_bid    = bid_q;
  assign bus.s_bresp  = bresp_q;

  always_comb begin
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (w_hs) begin
      if (w_last) begin
        wcnt_d   = '0;
        werr_d   = 1'b0;
        bvalid_d = 1'b1;
        bid_d    = aw_head.id;
        bresp_d  = (werr_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
        werr_d = werr_q | w_beat_err;
      end
    end else if (bvalid_q && bus.s_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read path: stream data is consumed only while a read burst is outstanding.
  assign bus.s_rvalid      = bus.s_axis_tvalid & ~ar_empty;
  assign bus.s_axis_tready = bus.s_rready & ~ar_empty;
  assign bus.s_rdata       = bus.s_axis_tdata;
  assign bus.s_rid         = ar_head.id;
  assign bus.s_rresp       = RESP_OKAY;
  assign r_hs              = bus.s_axis_tvalid & bus.s_rready & ~ar_empty;
  assign r_last            = (rcnt_q == ar_head.len);
  assign bus.s_rlast       = r_last;
  assign ar_pop            = r_hs & r_last;

  always_comb begin
    rcnt_d = rcnt_q;
    if (r_hs) rcnt_d = r_last ? 8'd0 : rcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rcnt_q   <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rcnt_q   <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_pcis_stream_bridge.sv
// Scoreboard bench for pcis_stream_bridge: directed bursts, negedge monitors.
module tb_pcis_stream_bridge;
  import pcis_bridge_pkg::*;

  localparam int unsigned DW  = 512;
  localparam int unsigned IW  = 6;
  localparam int          TMO = 500;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcis_stream_bridge_if #(.DATA_W(DW), .ID_W(IW), .ADDR_W(64)) bus ();

  pcis_stream_bridge #(
    .DATA_W   (DW),
    .ID_W     (IW),
    .ADDR_W   (64),
    .AQ_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {logic [DW-1:0] data; logic last;} s_exp_t;
  typedef struct {logic [IW-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [DW-1:0] data; logic [IW-1:0] id; logic last;} r_exp_t;

  s_exp_t exp_s[$];
  b_exp_t exp_b[$];
  r_exp_t exp_r[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + k;
    return {16{w}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  // ---------------- monitors (handshake decided at the next posedge) ----------------
  always @(negedge clk) begin
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_s.size() == 0) timeout("unexpected stream beat");
      else begin
        s_exp_t e;
        e = exp_s.pop_front();
        chk("m_axis_tdata", bus.m_axis_tdata, e.data);
        chk("m_axis_tlast", DW'(bus.m_axis_tlast), DW'(e.last));
      end
    end
    if (bus.s_bvalid && bus.s_bready) begin
      if (exp_b.size() == 0) timeout("unexpected B");
      else begin
        b_exp_t e;
        e = exp_b.pop_front();
        chk("s_bid", DW'(bus.s_bid), DW'(e.id));
        chk("s_bresp", DW'(bus.s_bresp), DW'(e.resp));
      end
    end
    if (bus.s_rvalid && bus.s_rready) begin
      if (exp_r.size() == 0) timeout("unexpected R");
      else begin
        r_exp_t e;
        e = exp_r.pop_front();
        chk("s_rdata", bus.s_rdata, e.data);
        chk("s_rid", DW'(bus.s_rid), DW'(e.id));
        chk("s_rlast", DW'(bus.s_rlast), DW'(e.last));
        chk("s_rresp", DW'(bus.s_rresp), DW'(RESP_OKAY));
      end
    end
  end

  // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
  task automatic aw_send(input logic [IW-1:0] id, input logic [7:0] len);
    int n = 0;
    bus.s_awid = id; bus.s_awlen = len; bus.s_awaddr = 64'h1000; bus.s_awsize = 3'd6;
    bus.s_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_awready && n < TMO);
    if (!bus.s_awready) timeout("aw");
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [IW-1:0] id, input logic [7:0] len);
    int n = 0;
    bus.s_arid = id; bus.s_arlen = len; bus.s_araddr = 64'h2000; bus.s_arsize = 3'd6;
    bus.s_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_arready && n < TMO);
    if (!bus.s_arready) timeout("ar");
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic last);
    int n = 0;
    bus.s_wdata = d; bus.s_wlast = last; bus.s_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_wready && n < TMO);
    if (!bus.s_wready) timeout("w");
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
  endtask

  task automatic s_send(input logic [DW-1:0] d);
    int n = 0;
    bus.s_axis_tdata = d; bus.s_axis_tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.s_axis_tready && n < TMO);
    if (!bus.s_axis_tready) timeout("s_axis");
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_s.size() + exp_b.size() + exp_r.size()) != 0 && n < TMO) begin
      @(negedge clk); n++;
    end
    chk("outstanding expectations", DW'(exp_s.size() + exp_b.size() + exp_r.size()), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic done;
    bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0; bus.s_awvalid = 0;
    bus.s_wdata = '0; bus.s_wstrb = '1; bus.s_wlast = 0; bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1;
    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0; bus.s_arvalid = 0;
    bus.s_rready = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tdata = pat(99); bus.s_axis_tvalid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: nothing queued, so W and stream are held off.
    @(negedge clk);
    chk("reset awready", DW'(bus.s_awready), DW'(1));
    chk("reset arready", DW'(bus.s_arready), DW'(1));
    chk("reset bvalid", DW'(bus.s_bvalid), '0);
    chk("reset tvalid", DW'(bus.m_axis_tvalid), '0);
    chk("reset wready", DW'(bus.s_wready), '0);
    chk("reset rvalid", DW'(bus.s_rvalid), '0);
    chk("reset s_axis_tready", DW'(bus.s_axis_tready), '0);
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0; bus.s_axis_tvalid = 1'b0;

    // Clean 4-beat write.
    for (int i = 0; i < 4; i++) exp_s.push_back('{pat(i), i == 3});
    exp_b.push_back('{6'd5, RESP_OKAY});
    aw_send(6'd5, 8'd3);
    for (int i = 0; i < 4; i++) w_send(pat(i), i == 3);
    drain();

    // Early wlast on beat 2: counter still drives tlast, B reports SLVERR.
    for (int i = 0; i < 4; i++) exp_s.push_back('{pat(10 + i), i == 3});
    exp_b.push_back('{6'd9, RESP_SLVERR});
    aw_send(6'd9, 8'd3);
    for (int i = 0; i < 4; i++) w_send(pat(10 + i), i == 1);
    drain();

    // W before AW, then B back-pressure blocks the next burst.
    bus.s_bready = 1'b0;
    exp_s.push_back('{pat(30), 1'b0});
    exp_s.push_back('{pat(31), 1'b1});
    exp_b.push_back('{6'd3, RESP_OKAY});
    fork
      begin
        cnt = 0;
        repeat (10) begin @(negedge clk); if (bus.s_wready) cnt++; end
        chk("wready before aw", DW'(cnt), '0);
        @(posedge clk); #1;
        aw_send(6'd3, 8'd1);
      end
      begin
        w_send(pat(30), 1'b0);
        w_send(pat(31), 1'b1);
      end
    join
    exp_s.push_back('{pat(32), 1'b1});
    exp_b.push_back('{6'd4, RESP_OKAY});
    aw_send(6'd4, 8'd0);
    fork
      w_send(pat(32), 1'b1);
      begin
        cnt = 0;
        repeat (5) begin @(negedge clk); if (bus.s_wready) cnt++; end
        chk("wready while B pending", DW'(cnt), '0);
        chk("bvalid held", DW'(bus.s_bvalid), DW'(1));
        chk("bid held", DW'(bus.s_bid), DW'(3));
        @(posedge clk); #1;
        bus.s_bready = 1'b1;
      end
    join
    drain();

    // AW queue full: fifth request stalls until the first burst completes.
    for (int i = 0; i < 5; i++) begin
      exp_s.push_back('{pat(40 + i), 1'b1});
      exp_b.push_back('{IW'(10 + i), RESP_OKAY});
    end
    for (int i = 0; i < 4; i++) aw_send(IW'(10 + i), 8'd0);
    fork
      aw_send(6'd14, 8'd0);
      begin
        cnt = 0;
        repeat (3) begin @(negedge clk); if (bus.s_awready) cnt++; end
        chk("awready when full", DW'(cnt), '0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) w_send(pat(40 + i), 1'b1);
      end
    join
    drain();

    // Two queued reads served from one stream.
    exp_r.push_back('{pat(50), 6'd2, 1'b0});
    exp_r.push_back('{pat(51), 6'd2, 1'b1});
    exp_r.push_back('{pat(52), 6'd7, 1'b1});
    ar_send(6'd2, 8'd1);
    ar_send(6'd7, 8'd0);
    for (int i = 0; i < 3; i++) s_send(pat(50 + i));
    drain();

    // 8-beat read with rready toggling every cycle.
    for (int i = 0; i < 8; i++) exp_r.push_back('{pat(60 + i), 6'd4, i == 7});
    ar_send(6'd4, 8'd7);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) s_send(pat(60 + i));
        done = 1'b1;
      end
      begin
        cnt = 0;
        while (!done && cnt < 4 * TMO) begin
          @(posedge clk); #1;
          bus.s_rready = ~bus.s_rready;
          cnt++;
        end
        bus.s_rready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a write burst and a read burst.
    exp_s.push_back('{pat(70), 1'b0});
    exp_s.push_back('{pat(71), 1'b0});
    aw_send(6'd1, 8'd3);
    w_send(pat(70), 1'b0);
    w_send(pat(71), 1'b0);
    exp_r.push_back('{pat(72), 6'd6, 1'b0});
    exp_r.push_back('{pat(73), 6'd6, 1'b0});
    ar_send(6'd6, 8'd7);
    s_send(pat(72));
    s_send(pat(73));
    bus.s_wvalid = 1'b1; bus.s_axis_tvalid = 1'b1;
    bus.m_axis_tready = 1'b0; bus.s_rready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1; bus.s_rready = 1'b1;
    @(negedge clk);
    chk("mid-reset tvalid", DW'(bus.m_axis_tvalid), '0);
    chk("mid-reset wready", DW'(bus.s_wready), '0);
    chk("mid-reset rvalid", DW'(bus.s_rvalid), '0);
    chk("mid-reset s_axis_tready", DW'(bus.s_axis_tready), '0);
    chk("mid-reset bvalid", DW'(bus.s_bvalid), '0);
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0; bus.s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset awready", DW'(bus.s_awready), DW'(1));
    chk("post-reset arready", DW'(bus.s_arready), DW'(1));
    @(posedge clk); #1;

    // Counters restart at zero: single-beat bursts end on their first beat.
    exp_s.push_back('{pat(80), 1'b1});
    exp_b.push_back('{6'd2, RESP_OKAY});
    aw_send(6'd2, 8'd0);
    w_send(pat(80), 1'b1);
    exp_r.push_back('{pat(81), 6'd5, 1'b1});
    ar_send(6'd5, 8'd0);
    s_send(pat(81));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
